// File: rtl/add_seq.sv
// add_seq: wide adder that time-multiplexes one shared 8-bit add, one limb per clock,
// least-significant limb first, with the inter-limb carry held in a register.
module add (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_ci,
    output logic [7:0] o_x,
    output logic       o_co
);
    assign {o_co, o_x} = {1'b0, i_a} + {1'b0, i_b} + {8'b0, i_ci};
endmodule

module add_seq #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start_valid,
    output logic               o_start_ready,
    input  logic [8*WORDS-1:0] i_op_a,
    input  logic [8*WORDS-1:0] i_op_b,
    input  logic               i_ci,
    output logic [8*WORDS-1:0] o_sum,
    output logic               o_co,
    output logic               o_busy,
    output logic               o_done
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                r_state, w_next;
    logic [IW-1:0]         r_idx;
    logic                  r_cy, r_co;
    logic [WORDS-1:0][7:0] r_a, r_b, r_sum;
    logic [7:0]            w_x;
    logic                  w_co, w_last;

    add u_add (
        .i_a  (r_a[r_idx]),
        .i_b  (r_b[r_idx]),
        .i_ci (r_cy),
        .o_x  (w_x),
        .o_co (w_co)
    );

    assign w_last        = (r_idx == IW'(WORDS - 1));
    assign o_start_ready = (r_state == S_IDLE);
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);
    assign o_sum         = r_sum;
    assign o_co          = r_co;

    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE && i_start_valid)
            w_next = S_RUN;
        else if (r_state == S_RUN && w_last)
            w_next = S_DONE;
        else if (r_state == S_DONE)
            w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Upper limbs of sum keep stale data until RUN reaches them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_cy  <= 1'b0;
            r_co  <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_sum <= '0;
        end else if (r_state == S_IDLE && i_start_valid) begin
            r_a   <= i_op_a;
            r_b   <= i_op_b;
            r_cy  <= i_ci;
            r_idx <= '0;
        end else if (r_state == S_RUN) begin
            r_sum[r_idx] <= w_x;
            r_cy         <= w_co;
            if (w_last)
                r_co <= w_co;
            else
                r_idx <= r_idx + 1'b1;
        end
    end
endmodule

// File: doc/add_seq.md
# add_seq

Multi-precision adder sequencer. It adds two WORDS×8-bit operands by time-multiplexing a single instance of the team's 8-bit `add` datapath (a, b, ci → x, co), one limb per clock, least-significant limb first. The inter-limb carry is held in a register between cycles. It accepts one operation through a valid/ready handshake and reports completion with a one-cycle `done` pulse. It sits between the control logic that issues wide additions and the shared 8-bit adder.

## Interface
- WORDS, 4, number of 8-bit limbs per operand; legal range 1..16
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start_valid  in  1  request to start an addition
- start_ready  out  1  block can accept a request (high only in IDLE)
- op_a  in  8*WORDS  operand A; limb i is op_a[8*i+7:8*i]
- op_b  in  8*WORDS  operand B; limb layout as op_a
- ci  in  1  carry-in to limb 0
- sum  out  8*WORDS  result register
- co  out  1  carry-out of the top limb
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle completion pulse

## Operation
- Instantiates exactly one `add`.
  - Its inputs are a_reg[idx], b_reg[idx] and the carry register `cy`.
  - Its outputs are x, which is written to sum[idx], and co, which is written to `cy`.
- The FSM has three states:
  - IDLE: start_ready=1, busy=0.
    - On start_valid=1 at a clock edge, capture op_a into a_reg, op_b into b_reg and ci into cy.
    - In the same edge, set idx=0 and go to RUN.
    - op_a, op_b and ci are don't-care after that edge.
  - RUN: start_ready=0, busy=1.
    - Each cycle, sum[idx] ← x and cy ← adder co.
    - If idx==WORDS-1, go to DONE and load co ← adder co. Otherwise idx ← idx+1.
  - DONE: done=1, busy=1, start_ready=0. The next state is IDLE unconditionally.
- Arithmetic:
  - {co, sum} = op_a + op_b + ci, computed modulo 2^(8*WORDS+1).
  - No signed interpretation; overflow only appears on co.
- Output hold rules:
  - sum and co hold their values from the done pulse until the next request is accepted.
  - During RUN, limbs of sum update progressively. Upper limbs keep stale data until they are written.
  - co is written only on the RUN→DONE transition.
- start_valid while start_ready=0 is ignored. It is not queued. The requester must hold start_valid until it sees start_ready=1 at a clock edge.
- idx width is clog2(WORDS), minimum 1 bit.
  - idx never wraps: it stops at WORDS-1.
  - For WORDS=1, RUN lasts exactly one cycle.

## Timing
- Reset values (rst_n=0, applied immediately without waiting for a clock edge):
  - state=IDLE, idx=0, cy=0
  - a_reg=0, b_reg=0, sum=0, co=0
  - done=0, busy=0, start_ready=1
- Latency, with the accept edge at E0:
  - RUN occupies the cycles after edges E0..E(WORDS-1).
  - done is high for the cycle after edge E(WORDS).
  - Final sum and co are valid in that same cycle.
- Throughput: one operation per WORDS+2 cycles. The earliest next accept is the edge that ends DONE+1; that is, start_ready rises in the cycle after the done pulse.
- Reset during RUN or DONE:
  - Return to IDLE immediately.
  - Discard the partial result. sum, co and cy go to 0.
  - No done pulse is produced for the aborted operation.
- Reset deasserted with start_valid=1: the accept happens on the first clock edge after rst_n rises. Synchronising the release of reset is the integrator's responsibility.

## Test plan
All scenarios use WORDS=4.
- Reset: assert rst_n=0 mid-cycle. Required: sum=0, co=0, done=0, busy=0 and start_ready=1 immediately, before any clock edge.
- Basic add: op_a=0x00000001, op_b=0x00000001, ci=1. Required: done exactly 5 cycles after the accept edge, with sum=0x00000003 and co=0.
- Full carry ripple: op_a=0xFFFFFFFF, op_b=0x00000001, ci=0. Required: sum=0x00000000, co=1.
- No-carry and cross-limb carry:
  - 0x0F0F0F0F + 0xF0F0F0F0, ci=0. Required: sum=0xFFFFFFFF, co=0.
  - 0x000000FF + 0x00000001, ci=0. Required: sum=0x00000100, co=0.
- Handshake:
  - Hold start_valid=1 continuously with changing operands. Required: each accept happens only when start_ready=1, results correspond to the operands present at each accept edge, and accepts are spaced 6 cycles apart.
  - Required: sum and co stay stable from done until the next accept.
- Reset mid-operation:
  - Start 0xFFFFFFFF + 0x00000001 and pulse rst_n low while idx=2. Required: no done pulse, sum=0 and co=0.
  - Then run 0x00000002 + 0x00000003, ci=0. Required: sum=0x00000005, co=0, proving no stale carry remains.
